// File: rtl/rs_pkg.sv
// Shared FU-class encoding used by the RS array, issue scheduler and CDB mux.
package rs_pkg;

    localparam int unsigned FU_SEL_W = 2;

    typedef enum logic [FU_SEL_W-1:0] {
        FU_SEL_NONE = 2'd0,
        FU_SEL_ALU  = 2'd1,
        FU_SEL_MULT = 2'd2,
        FU_SEL_DIV  = 2'd3
    } fu_sel_e;

endpackage

// File: rtl/rs_issue_sched_rr_arb.sv
// Round-robin arbiter: first request at or after ptr (wrapping) wins.
module rr_arb #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 vld,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned W = $clog2(N);

    logic [W-1:0] cand;

    always_comb begin
        gnt  = '0;
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = ptr + W'(off);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
        if (vld) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Per-class issue select for the RS array with CDB write-back slot reservation
// and divider occupancy tracking.
module rs_issue_sched
    import rs_pkg::*;
#(
    parameter int unsigned NUM_RS   = 8,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RS-1:0]            rs_rdy,
    input  logic [NUM_RS*FU_SEL_W-1:0]   rs_fu_sel,
    input  logic                         flush,
    input  logic                         div_wb_req,
    output logic [NUM_RS-1:0]            rs_iss_en,
    output logic                         alu_iss_vld,
    output logic                         mult_iss_vld,
    output logic                         div_iss_vld,
    output logic [$clog2(NUM_RS)-1:0]    alu_iss_idx,
    output logic [$clog2(NUM_RS)-1:0]    mult_iss_idx,
    output logic [$clog2(NUM_RS)-1:0]    div_iss_idx,
    output logic                         div_wb_gnt,
    output logic [FU_SEL_W-1:0]          cdb_src
);

    localparam int unsigned IDX_W = $clog2(NUM_RS);

    fu_sel_e           wb_slot [MULT_LAT];
    logic [IDX_W-1:0]  alu_ptr, mult_ptr, div_ptr;
    logic              div_busy_r;
    logic              div_gnt_pend;

    logic [NUM_RS-1:0] alu_req, mult_req, div_req;
    logic [NUM_RS-1:0] alu_gnt, mult_gnt, div_gnt;
    logic              issue_ok;
    fu_sel_e           sel;

    // Outputs are forced quiet while reset is asserted, not just after the edge.
    assign issue_ok = rst && !flush;

    always_comb begin
        alu_req  = '0;
        mult_req = '0;
        div_req  = '0;
        sel      = FU_SEL_NONE;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            sel         = fu_sel_e'(rs_fu_sel[i*FU_SEL_W +: FU_SEL_W]);
            alu_req[i]  = issue_ok && rs_rdy[i] && (sel == FU_SEL_ALU) && (wb_slot[1] == FU_SEL_NONE);
            mult_req[i] = issue_ok && rs_rdy[i] && (sel == FU_SEL_MULT);
            div_req[i]  = issue_ok && rs_rdy[i] && (sel == FU_SEL_DIV) && !div_busy_r;
        end
    end

    rr_arb #(.N(NUM_RS)) u_alu_arb (
        .req(alu_req), .ptr(alu_ptr), .gnt(alu_gnt), .vld(alu_iss_vld), .idx(alu_iss_idx)
    );
    rr_arb #(.N(NUM_RS)) u_mult_arb (
        .req(mult_req), .ptr(mult_ptr), .gnt(mult_gnt), .vld(mult_iss_vld), .idx(mult_iss_idx)
    );
    rr_arb #(.N(NUM_RS)) u_div_arb (
        .req(div_req), .ptr(div_ptr), .gnt(div_gnt), .vld(div_iss_vld), .idx(div_iss_idx)
    );

    assign rs_iss_en  = alu_gnt | mult_gnt | div_gnt;
    assign div_wb_gnt = issue_ok && div_wb_req && !div_gnt_pend && (wb_slot[0] == FU_SEL_NONE);
    assign cdb_src    = (wb_slot[0] != FU_SEL_NONE) ? wb_slot[0] :
                        div_wb_gnt                  ? FU_SEL_DIV : FU_SEL_NONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < MULT_LAT; k++) wb_slot[k] <= FU_SEL_NONE;
            alu_ptr      <= '0;
            mult_ptr     <= '0;
            div_ptr      <= '0;
            div_busy_r   <= 1'b0;
            div_gnt_pend <= 1'b0;
        end else if (flush) begin
            for (int unsigned k = 0; k < MULT_LAT; k++) wb_slot[k] <= FU_SEL_NONE;
            div_busy_r   <= 1'b0;
            div_gnt_pend <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < MULT_LAT - 1; k++) wb_slot[k] <= wb_slot[k+1];
            wb_slot[MULT_LAT-1] <= mult_iss_vld ? FU_SEL_MULT : FU_SEL_NONE;
            // ALU claims the slot that becomes current next cycle; never the top slot.
            if (alu_iss_vld) wb_slot[0] <= FU_SEL_ALU;
            if (alu_iss_vld)  alu_ptr  <= alu_iss_idx + 1'b1;
            if (mult_iss_vld) mult_ptr <= mult_iss_idx + 1'b1;
            if (div_iss_vld)  div_ptr  <= div_iss_idx + 1'b1;
            if (div_iss_vld)     div_busy_r <= 1'b1;
            else if (div_wb_gnt) div_busy_r <= 1'b0;
            div_gnt_pend <= div_wb_gnt;
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Randomized bench for rs_issue_sched against a cycle-booking reference model.
module tb_rs_issue_sched;
    import rs_pkg::*;

    localparam int N = 8;
    localparam int L = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 div_wb_req;
    logic [N-1:0]         rs_rdy;
    logic [N*FU_SEL_W-1:0] rs_fu_sel;
    logic [N-1:0]         rs_iss_en;
    logic                 alu_iss_vld, mult_iss_vld, div_iss_vld;
    logic [2:0]           alu_iss_idx, mult_iss_idx, div_iss_idx;
    logic                 div_wb_gnt;
    logic [FU_SEL_W-1:0]  cdb_src;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Model: CDB owner booked per absolute cycle (ring of 64), pointers, divider flags.
    int book [64];
    int ptr  [4];
    bit busy, pend;
    int cyc = 0;
    int sel [N];
    bit dv_pend;
    int dv_cnt;

    always #5 clk = ~clk;

    rs_issue_sched #(.NUM_RS(N), .MULT_LAT(L)) dut (
        .clk(clk), .rst(rst), .rs_rdy(rs_rdy), .rs_fu_sel(rs_fu_sel),
        .flush(flush), .div_wb_req(div_wb_req), .rs_iss_en(rs_iss_en),
        .alu_iss_vld(alu_iss_vld), .mult_iss_vld(mult_iss_vld), .div_iss_vld(div_iss_vld),
        .alu_iss_idx(alu_iss_idx), .mult_iss_idx(mult_iss_idx), .div_iss_idx(div_iss_idx),
        .div_wb_gnt(div_wb_gnt), .cdb_src(cdb_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [N-1:0] rdy);
        for (int i = 0; i < N; i++) rs_fu_sel[i*FU_SEL_W +: FU_SEL_W] = sel[i][1:0];
        rs_rdy = rdy;
    endtask

    function automatic int pick(input int c, input bit elig);
        int k;
        if (!elig) return -1;
        for (int off = 0; off < N; off++) begin
            k = (ptr[c] + off) % N;
            if (rs_rdy[k] && sel[k] == c) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) book[i] = 0;
        for (int c = 0; c < 4; c++) ptr[c] = 0;
        busy = 0; pend = 0; dv_pend = 0; dv_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        div_wb_req = 1'b1;
        for (int i = 0; i < N; i++) sel[i] = $urandom_range(0, 3);
        drive(8'hFF);
        #2;
        check("rst_iss_en", rs_iss_en, 0);
        check("rst_strobes", {alu_iss_vld, mult_iss_vld, div_iss_vld}, 0);
        check("rst_idx", {alu_iss_idx, mult_iss_idx, div_iss_idx}, 0);
        check("rst_gnt", div_wb_gnt, 0);
        check("rst_cdb", cdb_src, FU_SEL_NONE);
        model_reset();
        div_wb_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc++;
    endtask

    // One cycle: inputs already driven; compare at negedge, advance model, return at posedge+1.
    task automatic step();
        int g1, g2, g3, cur, exp_en;
        bit eg;
        @(negedge clk);
        cur = book[cyc % 64];
        g1 = pick(1, !flush && book[(cyc + 1) % 64] == 0);
        g2 = pick(2, !flush);
        g3 = pick(3, !flush && !busy);
        eg = !flush && div_wb_req && !pend && cur == 0;
        exp_en = 0;
        if (g1 >= 0) exp_en |= 1 << g1;
        if (g2 >= 0) exp_en |= 1 << g2;
        if (g3 >= 0) exp_en |= 1 << g3;
        check("iss_en", rs_iss_en, exp_en);
        check("alu", {alu_iss_vld, alu_iss_idx}, g1 >= 0 ? 8 + g1 : 0);
        check("mult", {mult_iss_vld, mult_iss_idx}, g2 >= 0 ? 8 + g2 : 0);
        check("div", {div_iss_vld, div_iss_idx}, g3 >= 0 ? 8 + g3 : 0);
        check("div_wb_gnt", div_wb_gnt, eg);
        check("cdb_src", cdb_src, cur != 0 ? cur : (eg ? 3 : 0));
        book[cyc % 64] = 0;
        if (flush) begin
            for (int i = 0; i < 64; i++) book[i] = 0;
            busy = 0; pend = 0; dv_pend = 0;
        end else begin
            if (g1 >= 0) begin book[(cyc + 1) % 64] = 1; ptr[1] = (g1 + 1) % N; end
            if (g2 >= 0) begin book[(cyc + L) % 64] = 2; ptr[2] = (g2 + 1) % N; end
            if (eg) begin busy = 0; dv_pend = 0; end
            if (g3 >= 0) begin
                busy = 1; ptr[3] = (g3 + 1) % N;
                dv_pend = 1; dv_cnt = $urandom_range(1, 12);
            end
            pend = eg;
        end
        cyc++;
        @(posedge clk); #1;
        div_wb_req = dv_pend && dv_cnt == 0;
        if (dv_pend && dv_cnt > 0) dv_cnt--;
        flush = 1'b0;
    endtask

    initial begin
        int seq [5];
        seq = '{1, 3, 5, 1, 3};
        flush = 1'b0;
        div_wb_req = 1'b0;
        for (int i = 0; i < N; i++) sel[i] = 0;
        rs_rdy = '0;
        rs_fu_sel = '0;
        rst = 1'b1;
        #1;
        do_reset();

        // Single ALU entry: same-cycle grant, CDB next cycle.
        for (int i = 0; i < N; i++) sel[i] = 0;
        sel[0] = 1;
        drive(8'h01); #1;
        check("t1_iss_en", rs_iss_en, 8'h01);
        check("t1_idx", alu_iss_idx, 0);
        step();
        drive(8'h00); #1;
        check("t1_cdb", cdb_src, FU_SEL_ALU);
        step();

        // Round-robin among ALU entries 1,3,5.
        sel[0] = 0; sel[1] = 1; sel[3] = 1; sel[5] = 1;
        for (int k = 0; k < 5; k++) begin
            drive(8'h2A); #1;
            check("rr_idx", alu_iss_idx, seq[k]);
            step();
        end
        drive(8'h00);
        for (int k = 0; k < L; k++) step();

        // MULT reservation blocks ALU write-back collision.
        for (int i = 0; i < N; i++) sel[i] = 0;
        sel[2] = 2; sel[0] = 1;
        drive(8'h04); step();
        drive(8'h00); step(); step();
        drive(8'h01); #1;
        check("mlat_alu_blocked", alu_iss_vld, 0);
        step();
        drive(8'h01); #1;
        check("mlat_alu_gnt", alu_iss_vld, 1);
        check("mlat_cdb_mult", cdb_src, FU_SEL_MULT);
        step();
        drive(8'h00); #1;
        check("mlat_cdb_alu", cdb_src, FU_SEL_ALU);
        step();

        // Two DIV entries held ready: divider occupancy serialises them.
        for (int i = 0; i < N; i++) sel[i] = 0;
        sel[6] = 3; sel[7] = 3; sel[4] = 2;
        for (int k = 0; k < 40; k++) begin
            drive(8'hC0 | ((k % 3 == 0) ? 8'h10 : 8'h00));
            step();
        end

        // All three classes at once after a flush clears divider occupancy.
        for (int i = 0; i < N; i++) sel[i] = 0;
        sel[2] = 1; sel[4] = 2; sel[6] = 3;
        drive(8'h00); flush = 1'b1; step();
        for (int k = 0; k < L; k++) step();
        drive(8'h54); #1;
        check("tri_iss_en", rs_iss_en, 8'h54);
        check("tri_strobes", {alu_iss_vld, mult_iss_vld, div_iss_vld}, 3'b111);
        step();

        // Flush with MULT in flight and divider busy.
        drive(8'h54); flush = 1'b1; #1;
        check("flush_iss_en", rs_iss_en, 0);
        check("flush_gnt", div_wb_gnt, 0);
        step();
        drive(8'h00);
        for (int k = 0; k < L + 1; k++) begin
            #1;
            check("flush_cdb_none", cdb_src, FU_SEL_NONE);
            step();
        end
        drive(8'h40); #1;
        check("flush_div_ok", div_iss_vld, 1);
        step();

        // Randomized traffic with occasional flush and mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                drive(8'h00);
            end
            for (int i = 0; i < N; i++) sel[i] = $urandom_range(0, 3);
            drive(N'($urandom));
            flush = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for the reservation stations. Each cycle it selects at most one ready entry per functional-unit class (ALU, MULT, DIV) and drives the per-entry issue enables that clear RS entries. It tracks divider occupancy and reserves future CDB write-back slots, so fixed-latency results never collide on the single CDB. It sits between the RS array and the FU/CDB mux.

## Interface
- NUM_RS, 8, number of RS entries (power of 2, ≥2)
- MULT_LAT, 4, multiplier issue-to-CDB latency in cycles (≥2); ALU latency fixed at 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rs_rdy  in  NUM_RS  entry valid with both operands ready
- rs_fu_sel  in  NUM_RS×FU_SEL_W  FU class per entry
- flush  in  1  pipeline flush (mispredict)
- div_wb_req  in  1  divider holds a finished result
- rs_iss_en  out  NUM_RS  entry issued this cycle (≤3 bits set, at most one per class)
- alu_iss_vld / mult_iss_vld / div_iss_vld  out  1  issue strobe per FU
- alu_iss_idx / mult_iss_idx / div_iss_idx  out  log2(NUM_RS)  issued entry index; 0 when not valid
- div_wb_gnt  out  1  divider may drive CDB this cycle
- cdb_src  out  FU_SEL_W  FU owning the CDB this cycle (NONE/ALU/MULT/DIV)

## Operation
- State: wb_slot[0..MULT_LAT-1] (FU id per future CDB cycle; slot 0 = current cycle), rr_ptr per class (log2(NUM_RS)), div_busy_r.
- Candidates per class: rs_rdy[i] && rs_fu_sel[i]==class. FU_SEL_NONE entries are never granted.
- Round-robin per class: search starts at rr_ptr. On grant, rr_ptr ← grant_idx+1 (mod NUM_RS). Pointer holds when there is no grant.
- ALU eligible iff wb_slot[1]==NONE. On ALU issue, next wb_slot[0] ← ALU.
- MULT is always eligible. On issue, next wb_slot[MULT_LAT-1] ← MULT.
- DIV eligible iff !div_busy_r. Issue sets div_busy_r. div_wb_gnt clears it. No DIV issue in the grant cycle.
- Shift every cycle: wb_slot[k] ← wb_slot[k+1]; top ← NONE unless MULT issues.
- div_wb_gnt = div_wb_req && !div_busy_clear_pending && wb_slot[0]==NONE. Fixed-latency units have CDB priority. div_wb_req held until granted.
- cdb_src = wb_slot[0] if not NONE, else DIV if div_wb_gnt, else NONE.
- flush: no grants that cycle. All wb_slot ← NONE, div_busy_r ← 0, rr_ptrs kept. div_wb_gnt forced 0.
- rs_iss_en = OR of the three one-hot grants.

## Timing
- Reset (rst low, async): wb_slot all NONE, rr_ptr 0, div_busy_r 0. All outputs 0, cdb_src NONE.
- Grant is combinational from rs_rdy in cycle t. The RS clears the entry at the edge ending t.
- ALU issued at t → cdb_src=ALU at t+1. MULT issued at t → cdb_src=MULT at t+MULT_LAT.
- ALU and MULT issued the same cycle never conflict (MULT_LAT≥2).
- DIV issued at t → next DIV issue earliest at g+1, where g is the div_wb_gnt cycle.
- Flush overrides every simultaneous issue/grant.
- Reset mid-operation discards all reservations.

## Structure
- Shared package (rs_pkg): FU_SEL_W=2, enum FU_SEL_NONE=0/ALU=1/MULT=2/DIV=3. Reused by RS and CDB mux.
- Sub-module rr_arb #(N) (request vector, pointer → one-hot grant, valid, index), instantiated once per class. Pointer registers live in rs_issue_sched.

## Test plan
- Reset then rs_rdy=8'h01, sel[0]=ALU → rs_iss_en=8'h01, alu_iss_idx=0 same cycle; cdb_src=ALU next cycle. During reset all outputs 0.
- Entries 1,3,5 ALU held ready → alu_iss_idx sequence 1,3,5,1,3.
- MULT (MULT_LAT=4) issued at t; ALU entry ready at t+3 → blocked at t+3, granted t+4. cdb_src MULT at t+4, ALU at t+5.
- DIV issued at t; second DIV entry ready stays ungranted. div_wb_req at t+10 with wb_slot[0]=MULT → gnt at t+11. Second DIV issues t+12.
- ALU, MULT, DIV entries 2,4,6 ready same cycle → rs_iss_en=8'h54, three strobes.
- MULT in flight plus div_busy, flush asserted → no grants. cdb_src NONE for all following cycles. DIV eligible next cycle.
